// File: rtl/fetch_ctrl_pkg.sv
// Shared types for the fetch-stage sequencer.
// Holds the controller state encoding and the default address width.
package pipeline_pkg;
    typedef enum logic [1:0] {BOOT, FETCH, STALL} fetch_state_t;
    localparam int XLEN = 32;
endpackage

// File: rtl/fetch_ctrl_if.sv
// Control bundle between the fetch sequencer and hazard logic, execute and fetch datapath.
// The master side is the sequencer; the slave side is the surrounding pipeline.
interface fetch_ctrl_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             PCSrcE;
    logic [XLEN-1:0]  PCTargetE;
    logic             i_stall_d;
    logic             i_imem_ack;
    logic             o_imem_req;
    logic             o_pc_en;
    logic             o_pc_sel;
    logic [XLEN-1:0]  o_pc_target;
    logic             o_fd_en;
    logic             o_fd_flush;
    logic             o_de_flush;
    logic [CNT_W-1:0] o_wait_cnt;

    modport master (
        input  PCSrcE, PCTargetE, i_stall_d, i_imem_ack,
        output o_imem_req, o_pc_en, o_pc_sel, o_pc_target,
        output o_fd_en, o_fd_flush, o_de_flush, o_wait_cnt
    );
    modport slave (
        output PCSrcE, PCTargetE, i_stall_d, i_imem_ack,
        input  o_imem_req, o_pc_en, o_pc_sel, o_pc_target,
        input  o_fd_en, o_fd_flush, o_de_flush, o_wait_cnt
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: PC enable/select, IF/ID enable/flush, ID/EX flush.
// Tolerates variable imem latency and buffers redirects that land while a fetch is in flight.
module fetch_ctrl #(
    parameter int XLEN        = pipeline_pkg::XLEN,
    parameter int BOOT_CYCLES = 4,
    parameter int CNT_W       = 16
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    fetch_ctrl_if.master  bus
);
    import pipeline_pkg::*;

    localparam int BW = $clog2(BOOT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [BW-1:0]    BOOT_INIT = BW'(BOOT_CYCLES - 1);

    fetch_state_t     state_q, state_d;
    logic [BW-1:0]    boot_cnt_q, boot_cnt_d;
    logic             redir_pend_q, redir_pend_d;
    logic [XLEN-1:0]  redir_tgt_q, redir_tgt_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             redir, fd_en, fd_flush;

    // Redirects are meaningless before the first fetch, so BOOT masks them.
    assign redir = bus.PCSrcE && (state_q != BOOT);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= BOOT;
            boot_cnt_q   <= BOOT_INIT;
            redir_pend_q <= 1'b0;
            redir_tgt_q  <= '0;
            wait_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            boot_cnt_q   <= boot_cnt_d;
            redir_pend_q <= redir_pend_d;
            redir_tgt_q  <= redir_tgt_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        boot_cnt_d     = boot_cnt_q;
        redir_pend_d   = redir_pend_q;
        redir_tgt_d    = redir_tgt_q;
        wait_cnt_d     = wait_cnt_q;
        bus.o_imem_req = 1'b0;
        bus.o_pc_en    = 1'b0;
        bus.o_pc_sel   = 1'b0;
        fd_en          = 1'b0;
        fd_flush       = redir;
        case (state_q)
            BOOT: begin
                fd_flush = 1'b1;
                if (boot_cnt_q == '0) state_d = FETCH;
                else                  boot_cnt_d = boot_cnt_q - 1'b1;
            end
            FETCH: begin
                bus.o_imem_req = 1'b1;
                if (!bus.i_imem_ack && wait_cnt_q != CNT_MAX)
                    wait_cnt_d = wait_cnt_q + 1'b1;
                if (redir) begin
                    if (bus.i_imem_ack) begin
                        bus.o_pc_en  = 1'b1;
                        bus.o_pc_sel = 1'b1;
                        redir_pend_d = 1'b0;
                    end else begin
                        // PC must stay put under an outstanding request; newest target wins.
                        redir_pend_d = 1'b1;
                        redir_tgt_d  = bus.PCTargetE;
                    end
                end else if (bus.i_imem_ack) begin
                    if (redir_pend_q) begin
                        bus.o_pc_en  = 1'b1;
                        bus.o_pc_sel = 1'b1;
                        fd_flush     = 1'b1;
                        redir_pend_d = 1'b0;
                    end else if (bus.i_stall_d) begin
                        state_d = STALL;
                    end else begin
                        bus.o_pc_en = 1'b1;
                        fd_en       = 1'b1;
                    end
                end
            end
            STALL: begin
                if (redir) begin
                    bus.o_pc_en  = 1'b1;
                    bus.o_pc_sel = 1'b1;
                    state_d      = FETCH;
                end else if (!bus.i_stall_d) begin
                    state_d = FETCH;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    assign bus.o_de_flush  = redir;
    assign bus.o_fd_flush  = fd_flush;
    assign bus.o_fd_en     = fd_en & ~fd_flush;
    assign bus.o_pc_target = redir ? bus.PCTargetE : redir_tgt_q;
    assign bus.o_wait_cnt  = wait_cnt_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: directed scenarios plus random traffic against a cycle model.
// A narrow wait counter is used so saturation is reachable.
module tb_fetch_ctrl;
    localparam int XLEN  = 32;
    localparam int BOOT  = 4;
    localparam int CNT_W = 4;
    localparam int WMAX  = (1 << CNT_W) - 1;

    typedef struct packed {
        logic             req;
        logic             pc_en;
        logic             pc_sel;
        logic [XLEN-1:0]  tgt;
        logic             fd_en;
        logic             fd_flush;
        logic             de_flush;
        logic [CNT_W-1:0] wcnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_ctrl_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus();
    fetch_ctrl #(.XLEN(XLEN), .BOOT_CYCLES(BOOT), .CNT_W(CNT_W)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus)
    );

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: cycles of boot left, whether decode holds us, and a one-deep redirect slot.
    int              boot_left = BOOT;
    bit              stalled = 1'b0;
    bit              pend = 1'b0;
    logic [XLEN-1:0] pend_addr = '0;
    int              waits = 0;

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input bit rst, input bit pcs, input logic [XLEN-1:0] tgt,
                         input bit stall, input bit ack);
        exp_t e;
        bit   active;
        @(posedge clk); #1;
        rst_n          = rst;
        bus.PCSrcE     = pcs;
        bus.PCTargetE  = tgt;
        bus.i_stall_d  = stall;
        bus.i_imem_ack = ack;
        e = '0;
        if (!rst) begin
            boot_left = BOOT; stalled = 0; pend = 0; pend_addr = '0; waits = 0;
        end
        active = rst && boot_left == 0;
        e.wcnt = CNT_W'(waits);
        e.tgt  = (active && pcs) ? tgt : pend_addr;
        if (!active) begin
            e.fd_flush = 1'b1;
            if (rst) boot_left--;
        end else if (stalled) begin
            if (pcs) begin
                e.pc_en = 1; e.pc_sel = 1; e.fd_flush = 1; e.de_flush = 1; stalled = 0;
            end else if (!stall) stalled = 0;
        end else begin
            e.req = 1'b1;
            if (!ack && waits < WMAX) waits++;
            if (pcs) begin
                e.fd_flush = 1; e.de_flush = 1;
                if (ack) begin e.pc_en = 1; e.pc_sel = 1; pend = 0; end
                else begin pend = 1; pend_addr = tgt; end
            end else if (ack) begin
                if (pend)       begin e.pc_en = 1; e.pc_sel = 1; e.fd_flush = 1; pend = 0; end
                else if (stall) stalled = 1;
                else            begin e.pc_en = 1; e.fd_en = 1; end
            end
        end
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("imem_req",  XLEN'(bus.o_imem_req),  XLEN'(e.req));
            chk("pc_en",     XLEN'(bus.o_pc_en),     XLEN'(e.pc_en));
            chk("pc_sel",    XLEN'(bus.o_pc_sel),    XLEN'(e.pc_sel));
            chk("pc_target", bus.o_pc_target,        e.tgt);
            chk("fd_en",     XLEN'(bus.o_fd_en),     XLEN'(e.fd_en));
            chk("fd_flush",  XLEN'(bus.o_fd_flush),  XLEN'(e.fd_flush));
            chk("de_flush",  XLEN'(bus.o_de_flush),  XLEN'(e.de_flush));
            chk("wait_cnt",  XLEN'(bus.o_wait_cnt),  XLEN'(e.wcnt));
        end
    end

    initial begin
        bus.PCSrcE = 0; bus.PCTargetE = '0; bus.i_stall_d = 0; bus.i_imem_ack = 0;
        // Reset with noisy inputs, then release with ack tied high.
        for (int i = 0; i < 3; i++) drive(0, 1, 32'hdead_beef, 1, 1);
        for (int i = 0; i < 10; i++) drive(1, 0, '0, 0, 1);
        // Ack every third cycle.
        for (int i = 0; i < 6; i++) drive(1, 0, '0, 0, (i % 3) == 2);
        // Redirect coinciding with ack.
        drive(1, 1, 32'h100, 0, 1);
        // Two redirects while waiting; the newer target must win at ack.
        drive(1, 1, 32'h200, 0, 0);
        drive(1, 0, '0, 0, 0);
        drive(1, 1, 32'h300, 0, 0);
        drive(1, 0, '0, 0, 0);
        drive(1, 0, '0, 0, 1);
        drive(1, 0, '0, 0, 1);
        // Load-use stall held two cycles, then a redirect out of a stall.
        drive(1, 0, '0, 1, 1);
        drive(1, 0, '0, 1, 0);
        drive(1, 0, '0, 0, 0);
        drive(1, 0, '0, 0, 1);
        drive(1, 0, '0, 1, 1);
        drive(1, 1, 32'h400, 1, 0);
        drive(1, 0, '0, 0, 1);
        // Reset while a fetch and a redirect are both outstanding.
        drive(1, 1, 32'h500, 0, 0);
        drive(0, 0, '0, 0, 1);
        drive(0, 1, 32'h600, 0, 1);
        for (int i = 0; i < 7; i++) drive(1, 0, '0, 0, 1);
        // Long memory wait saturates the counter.
        for (int i = 0; i < 20; i++) drive(1, 0, '0, 0, 0);
        drive(1, 0, '0, 0, 1);
        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++)
            drive($urandom_range(0, 199) != 0, $urandom_range(0, 7) == 0,
                  {$urandom_range(0, 32'h3fff_ffff), 2'b00},
                  $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("queue_drained", XLEN'(q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
